// File: rtl/mig_resp_if.sv
// Command/response bus between a UI initiator and the mig_resp memory model.
// The master modport is the initiator; the slave modport is the memory side.
interface mig_resp_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 28
);
    logic                  en_i;
    logic                  w_en_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     data_i;
    logic [DATA_W/8-1:0]   strb_i;
    logic                  ready_o;
    logic                  w_ready_o;
    logic                  valid_o;
    logic [DATA_W-1:0]     data_o;

    modport master (
        output en_i, w_en_i, addr_i, data_i, strb_i,
        input  ready_o, w_ready_o, valid_o, data_o
    );

    modport slave (
        input  en_i, w_en_i, addr_i, data_i, strb_i,
        output ready_o, w_ready_o, valid_o, data_o
    );
endinterface

// File: rtl/mig_resp.sv
// Behavioural stand-in for a DDR controller UI: calibration delay, byte-masked
// writes, fixed-latency reads. Define MIG_RESP_BACKPRESSURE_EN for LFSR stalls.
//
// state | meaning
// CALIB | post-reset calibration, UI held in reset, no commands accepted
// RUN   | commands accepted (subject to optional pseudo-random stalls)
module mig_resp #(
    parameter int DATA_W       = 128,
    parameter int ADDR_W       = 28,
    parameter int MEM_DEPTH    = 64,
    parameter int RD_LAT       = 4,
    parameter int CALIB_CYCLES = 16
) (
    input  logic       sys_clk_i,
    input  logic       sys_reset_i,
    mig_resp_if.slave  bus,
    output logic       ui_clk_o,
    output logic       ui_reset_no
);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;

    typedef enum logic {CALIB, RUN} state_t;

    state_t              state;
    logic [CNT_W-1:0]    calib_cnt;
    logic                ready_q;
    logic                w_ready_q;
    logic                rdy_run;
    logic                wrdy_run;

    logic                wr_acc;
    logic                rd_acc;
    logic [IDX_W-1:0]    rd_idx;
    logic                wr_pend;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic [RD_LAT-1:0]   vld_pipe;
    logic [DATA_W-1:0]   dat_pipe [RD_LAT];
    logic                unused_addr_hi;

`ifdef MIG_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign rdy_run  = lfsr_nxt[0];
    assign wrdy_run = lfsr_nxt[8];

    always_ff @(posedge sys_clk_i) begin
        if (sys_reset_i) lfsr <= 16'hACE1;
        else             lfsr <= lfsr_nxt;
    end
`else
    assign rdy_run  = 1'b1;
    assign wrdy_run = 1'b1;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (sys_reset_i) begin
            state       <= CALIB;
            calib_cnt   <= '0;
            ready_q     <= 1'b0;
            w_ready_q   <= 1'b0;
            ui_reset_no <= 1'b0;
        end else begin
            case (state)
                CALIB: begin
                    if (calib_cnt == CNT_W'(CALIB_CYCLES - 1)) begin
                        state       <= RUN;
                        ready_q     <= rdy_run;
                        w_ready_q   <= wrdy_run;
                        ui_reset_no <= 1'b1;
                    end else begin
                        calib_cnt <= calib_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    ready_q   <= rdy_run;
                    w_ready_q <= wrdy_run;
                end
                default: state <= CALIB;
            endcase
        end
    end

    assign wr_acc = bus.en_i &  bus.w_en_i & ready_q & w_ready_q;
    assign rd_acc = bus.en_i & ~bus.w_en_i & ready_q;
    assign rd_idx = bus.addr_i[IDX_W-1:0];
    assign unused_addr_hi = ^bus.addr_i[ADDR_W-1:IDX_W];

    // Writes land one cycle after acceptance; the pending word is forwarded to reads.
    always_ff @(posedge sys_clk_i) begin
        if (sys_reset_i) begin
            wr_pend <= 1'b0;
        end else begin
            wr_pend <= wr_acc;
            if (wr_acc) begin
                wr_idx  <= rd_idx;
                wr_data <= bus.data_i;
                wr_strb <= bus.strb_i;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (wr_pend && !sys_reset_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_pend && (wr_idx == rd_idx)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) rd_word[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    // Data stages only load behind a valid, so the output word holds between responses.
    always_ff @(posedge sys_clk_i) begin
        if (sys_reset_i) begin
            vld_pipe <= '0;
            for (int k = 0; k < RD_LAT; k++) dat_pipe[k] <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            if (rd_acc) dat_pipe[0] <= rd_word;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign bus.ready_o   = ready_q;
    assign bus.w_ready_o = w_ready_q;
    assign bus.valid_o   = vld_pipe[RD_LAT-1];
    assign bus.data_o    = dat_pipe[RD_LAT-1];
    assign ui_clk_o      = sys_clk_i;
endmodule

// File: tb/tb_mig_resp.sv
// Directed and scoreboard-driven checks for mig_resp at default parameters.
module tb_mig_resp;
    localparam int DW    = 128;
    localparam int AW    = 28;
    localparam int SW    = 16;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ui_clk;
    logic ui_rstn;

    mig_resp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mig_resp #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .RD_LAT(4), .CALIB_CYCLES(16)
    ) dut (
        .sys_clk_i  (clk),
        .sys_reset_i(rst),
        .bus        (bus),
        .ui_clk_o   (ui_clk),
        .ui_reset_no(ui_rstn)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    bit mon_en = 1'b0;
    int n_resp = 0;
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r = old_w;
        for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic issue(input bit w, input int a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit ok = 1'b0;
        bus.en_i   = 1'b1;
        bus.w_en_i = w;
        bus.addr_i = AW'(a);
        bus.data_i = d;
        bus.strb_i = s;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (bus.ready_o === 1'b1 && (!w || bus.w_ready_o === 1'b1)) begin
                ok = 1'b1;
                if (w) mdl[a % DEPTH] = merge(mdl[a % DEPTH], d, s);
                else if (mon_en) exp_q.push_back(mdl[a % DEPTH]);
            end
            cyc();
        end
        bus.en_i = 1'b0;
        if (!ok) chk("accept_timeout", DW'(ok), DW'(1));
    endtask

    task automatic read_expect(input int a, input logic [DW-1:0] exp, input string tag);
        int lat = 1;
        issue(1'b0, a, '0, '0);
        while (bus.valid_o !== 1'b1 && lat < 20) begin
            cyc();
            lat++;
        end
        chk({tag, "_lat"}, DW'(lat), DW'(4));
        chk({tag, "_data"}, bus.data_o, exp);
        cyc();
        chk({tag, "_pulse"}, DW'(bus.valid_o), DW'(0));
        chk({tag, "_hold"}, bus.data_o, exp);
    endtask

    // Counts calibration cycles (UI reset low) and watches for stray ready/valid.
    task automatic wait_calib(output int n, output bit rdy_seen, output bit vld_seen);
        n = 0; rdy_seen = 1'b0; vld_seen = 1'b0;
        while (ui_rstn !== 1'b1 && n < 100) begin
            if (bus.ready_o !== 1'b0) rdy_seen = 1'b1;
            if (bus.valid_o !== 1'b0) vld_seen = 1'b1;
            n++;
            cyc();
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.valid_o === 1'b1) begin
            n_resp++;
            chk("rand_resp_pending", DW'(exp_q.size() != 0), DW'(1));
            if (exp_q.size() != 0) chk("rand_data", bus.data_o, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int n_rd;
        bit rdy_seen;
        bit vld_seen;
        logic [7:0] bv;
        logic [DW-1:0] pat;
        logic gv [16];
        logic [DW-1:0] got [16];

        bus.en_i = 1'b0; bus.w_en_i = 1'b0; bus.addr_i = '0; bus.data_i = '0; bus.strb_i = '0;
        repeat (3) cyc();
        chk("rst_ready",   DW'(bus.ready_o),   DW'(0));
        chk("rst_w_ready", DW'(bus.w_ready_o), DW'(0));
        chk("rst_valid",   DW'(bus.valid_o),   DW'(0));
        chk("rst_data",    bus.data_o,         '0);
        chk("rst_ui_rstn", DW'(ui_rstn),       DW'(0));
        chk("ui_clk",      DW'(ui_clk),        DW'(clk));

        rst = 1'b0;
        wait_calib(n, rdy_seen, vld_seen);
        chk("calib_len",        DW'(n),        DW'(16));
        chk("calib_ready_low",  DW'(rdy_seen), DW'(0));
        chk("calib_ui_rstn_hi", DW'(ui_rstn),  DW'(1));
`ifndef MIG_RESP_BACKPRESSURE_EN
        chk("run_ready",   DW'(bus.ready_o),   DW'(1));
        chk("run_w_ready", DW'(bus.w_ready_o), DW'(1));
`endif

        issue(1'b1, 5, {16{8'hAA}}, '1);
        read_expect(5, {16{8'hAA}}, "rd5");
        issue(1'b1, 5, {16{8'h55}}, 16'h0000);
        read_expect(5, {16{8'hAA}}, "strb_zero");
        issue(1'b1, 3, '0, '1);
        issue(1'b1, 3, '1, 16'h000F);
        read_expect(3, {96'h0, 32'hFFFF_FFFF}, "strb_lo");
        issue(1'b1, 2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '1);
        read_expect(66, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, "wrap");

        for (int i = 0; i < 8; i++) begin
            bv = 8'h10 + 8'(i);
            issue(1'b1, i, {16{bv}}, '1);
        end

`ifndef MIG_RESP_BACKPRESSURE_EN
        for (int c = 0; c < 16; c++) begin
            bus.en_i   = (c < 8);
            bus.w_en_i = 1'b0;
            bus.addr_i = AW'(c);
            gv[c]  = bus.valid_o;
            got[c] = bus.data_o;
            cyc();
        end
        bus.en_i = 1'b0;
        for (int c = 0; c < 16; c++)
            chk($sformatf("b2b_valid%0d", c), DW'(gv[c]), DW'(c >= 4 && c < 12));
        for (int i = 0; i < 8; i++) begin
            bv  = 8'h10 + 8'(i);
            pat = {16{bv}};
            chk($sformatf("b2b_data%0d", i), got[4 + i], pat);
        end

        vld_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.en_i   = 1'b1;
            bus.w_en_i = 1'b0;
            bus.addr_i = AW'(c);
            rst = (c >= 2);
            if (bus.valid_o !== 1'b0) vld_seen = 1'b1;
            cyc();
        end
        rst = 1'b0;
        bus.en_i = 1'b0;
        wait_calib(n, rdy_seen, vld_seen);
        chk("midrst_no_valid", DW'(vld_seen), DW'(0));
        chk("midrst_calib",    DW'(n),        DW'(16));
        read_expect(1, {16{8'h11}}, "post_rst");
`endif

        mon_en = 1'b1;
        n_rd = 0;
        for (int a = 0; a < DEPTH; a++)
            issue(1'b1, a, {$urandom, $urandom, $urandom, $urandom}, '1);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                n_rd++;
                issue(1'b0, int'($urandom_range(0, 127)), '0, '0);
            end else begin
                issue(1'b1, int'($urandom_range(0, 127)),
                      {$urandom, $urandom, $urandom, $urandom}, SW'($urandom));
            end
        end
        repeat (10) cyc();
        chk("rand_resp_count",  DW'(n_resp),       DW'(n_rd));
        chk("rand_queue_empty", DW'(exp_q.size()), DW'(0));
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
